normalize_pack_float: RTL and testbench
=======================================

NORMALIZE_PACK_FLOAT -- requirements
Module: normalize_pack_float

Interface
REQ-001 Parameter SCALE_W, default 8: width of the signed two's-complement dequantization exponent offset.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 in_valid  in  1  input beat present.
REQ-005 in_ready  out  1  block accepts the beat this cycle; transfer occurs when in_valid && in_ready.
REQ-006 in_word  in  32  unsigned magnitude, the same word presented to the leading-one detector.
REQ-007 in_loc  in  6  leading-one position from the detector: 0 means word is zero; k in 1..32 means the MSB one is at bit k-1. It is aligned to in_word by the upstream delay register.
REQ-008 in_sign  in  1  sign of the dequantized value.
REQ-009 in_scale  in  SCALE_W  signed power-of-two scale added to the exponent.
REQ-010 out_valid  out  1  output beat present.
REQ-011 out_ready  in  1  downstream accepts; transfer when out_valid && out_ready.
REQ-012 out_data  out  32  IEEE-754 binary32 result.
REQ-013 out_uf  out  1  result flushed to signed zero by exponent underflow.
REQ-014 out_of  out  1  result saturated to signed infinity by exponent overflow.

Function
REQ-015 The block SHALL be a two-stage valid/ready pipeline: S1 normalize, S2 round/pack; latency exactly 2 cycles from accept to out_valid when not stalled.
REQ-016 Each stage SHALL load when it is empty or the next stage loads/drains in the same cycle; in_ready = !s1_valid || (!s2_valid || out_ready), combinational, with no beat lost or duplicated.
REQ-017 Full throughput: with out_ready held high, SHALL accept one beat per cycle.
REQ-018 S1: norm[31:0] = in_word << (32 - in_loc), for in_loc in 1..32. When in_loc = 0, norm = 0 and a zero flag is registered.
REQ-019 S1: exponent e = 126 + in_loc + sext(in_scale), computed signed in SCALE_W+3 bits; register sign, zero flag, norm and e.
REQ-020 S2: mantissa m = norm[30:8], guard G = norm[7], sticky S = |norm[6:0].
REQ-021 S2 rounding is selected per REQ-030; a mantissa carry-out (m all ones and rounded up) SHALL set m = 0 and increment e by 1.
REQ-022 Zero flag set: out_data = {sign, 31'b0}, out_uf = 0, out_of = 0.
REQ-023 Post-round e <= 0: out_data = {sign, 31'b0}, out_uf = 1; no subnormals are produced.
REQ-024 Post-round e >= 255: out_data = {sign, 8'hFF, 23'b0}, out_of = 1.
REQ-025 Otherwise: out_data = {sign, e[7:0], m}, flags 0.
REQ-026 in_loc values 33..63 are illegal; the behaviour is don't-care, but the block SHALL NOT hang the handshake.
REQ-027 out_data and the flags SHALL be held stable while out_valid && !out_ready.

Reset
REQ-028 On rst assertion the block SHALL clear s1_valid, s2_valid and out_valid immediately, without waiting for clk. out_data, out_uf and out_of SHALL reset to 0.
REQ-029 Reset mid-operation SHALL discard all in-flight beats. in_ready SHALL be 1 in the first cycle after rst deasserts.

Configuration
REQ-030 Macro ROUND_NEAREST_EN defined: round-to-nearest-even, incrementing m when G && (S || m[0]). Macro undefined: truncation, with m used as-is and no carry path.

Verification
REQ-031 in_word=1, in_loc=1, sign=0, scale=0 -> out_data=0x3F800000, 2 cycles after accept, flags 0.
REQ-032 in_word=0x80000000, in_loc=32, sign=1, scale=0 -> out_data=0xCF000000.
REQ-033 in_word=0x01FFFFFF, in_loc=25, scale=0 -> 0x4C000000 with ROUND_NEAREST_EN, 0x4BFFFFFF without it.
REQ-034 Exponent limits: in_word=1, in_loc=1, scale=-128 -> 0x00000000, out_uf=1. in_word=0x80000000, in_loc=32, scale=+127 -> 0x7F800000, out_of=1. in_loc=0, sign=1 -> 0x80000000, flags 0.
REQ-035 Backpressure: out_ready low for 4 cycles while 4 beats are offered back-to-back -> exactly 2 are accepted and in_ready falls; after out_ready rises all 4 emerge in order with no gaps.
REQ-036 Reset mid-operation: assert rst between clock edges while out_valid=1 -> out_valid and out_data read 0 before the next edge, and no stale beat appears after release.

Source files
------------

// File: rtl/normalize_pack_float.sv
// normalize_pack_float: two-stage valid/ready pipeline that turns an unsigned
// magnitude plus its leading-one position, sign and power-of-two scale into
// an IEEE-754 binary32 word.
//   S1: left-justify the magnitude and form the biased exponent.
//   S2: round (or truncate), then pack, with underflow flush and overflow saturation.
// Optional build macro: ROUND_NEAREST_EN selects round-to-nearest-even;
// when it is left undefined, the mantissa is truncated.
module normalize_pack_float #(
  parameter int SCALE_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        in_word,
  input  logic [5:0]         in_loc,
  input  logic               in_sign,
  input  logic [SCALE_W-1:0] in_scale,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        out_data,
  output logic               out_uf,
  output logic               out_of
);

  localparam int EW = SCALE_W + 3;
  localparam logic signed [EW-1:0] EXP_SAT = EW'(255);

  // Stage 1 state
  logic                 r_s1_valid;
  logic                 r_s1_sign;
  logic                 r_s1_zero;
  logic [31:0]          r_s1_norm;
  logic signed [EW-1:0] r_s1_exp;

  // Stage 2 / output state
  logic                 r_s2_valid;
  logic [31:0]          r_out_data;
  logic                 r_out_uf;
  logic                 r_out_of;

  logic                 w_s1_ld;
  logic                 w_s2_ld;
  logic [5:0]           w_shamt;
  logic [31:0]          w_norm;
  logic signed [EW-1:0] w_exp;
  logic [22:0]          w_mant_raw;
  logic [22:0]          w_mant;
  logic signed [EW-1:0] w_exp_rnd;
  logic [31:0]          w_pack_data;
  logic                 w_pack_uf;
  logic                 w_pack_of;
  logic                 w_unused_bits;

  // A stage loads when it is empty or its contents move on this same cycle
  assign in_ready  = !r_s1_valid || !r_s2_valid || out_ready;
  assign w_s1_ld   = in_valid && in_ready;
  assign w_s2_ld   = r_s1_valid && (!r_s2_valid || out_ready);

  assign out_valid = r_s2_valid;
  assign out_data  = r_out_data;
  assign out_uf    = r_out_uf;
  assign out_of    = r_out_of;

  // Normalize: move the leading one to bit 31; biased exponent = 126 + loc + scale
  always_comb begin
    w_shamt = 6'd32 - in_loc;
    w_norm  = (in_loc == 6'd0) ? '0 : (in_word << w_shamt);
    w_exp   = EW'(126) + EW'(in_loc) + {{3{in_scale[SCALE_W-1]}}, in_scale};
  end

  // Round (optional) and pack the stage-1 beat into binary32 with exception handling
  always_comb begin
    w_mant_raw = r_s1_norm[30:8];
    w_mant     = w_mant_raw;
    w_exp_rnd  = r_s1_exp;
`ifdef ROUND_NEAREST_EN
    // An all-ones mantissa that rounds up wraps to zero and carries into the exponent
    if (r_s1_norm[7] && ((|r_s1_norm[6:0]) || w_mant_raw[0])) begin
      w_mant = w_mant_raw + 23'd1;
      if (&w_mant_raw) begin
        w_exp_rnd = r_s1_exp + EW'(1);
      end
    end
    w_unused_bits = r_s1_norm[31];
`else
    w_unused_bits = r_s1_norm[31] ^ (^r_s1_norm[7:0]);
`endif
    w_pack_uf   = 1'b0;
    w_pack_of   = 1'b0;
    w_pack_data = {r_s1_sign, w_exp_rnd[7:0], w_mant};
    if (r_s1_zero) begin
      w_pack_data = {r_s1_sign, 31'd0};
    end else if (w_exp_rnd[EW-1] || (w_exp_rnd == '0)) begin
      w_pack_data = {r_s1_sign, 31'd0};
      w_pack_uf   = 1'b1;
    end else if (w_exp_rnd >= EXP_SAT) begin
      w_pack_data = {r_s1_sign, 8'hFF, 23'd0};
      w_pack_of   = 1'b1;
    end
  end

  // Stage 1 register: capture the normalized beat on accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_sign  <= 1'b0;
      r_s1_zero  <= 1'b0;
      r_s1_norm  <= '0;
      r_s1_exp   <= '0;
    end else if (w_s1_ld) begin
      r_s1_valid <= 1'b1;
      r_s1_sign  <= in_sign;
      r_s1_zero  <= (in_loc == 6'd0);
      r_s1_norm  <= w_norm;
      r_s1_exp   <= w_exp;
    end else if (w_s2_ld) begin
      r_s1_valid <= 1'b0;
    end
  end

  // Stage 2 register: packed result, held while the consumer stalls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_out_data <= '0;
      r_out_uf   <= 1'b0;
      r_out_of   <= 1'b0;
    end else if (w_s2_ld) begin
      r_s2_valid <= 1'b1;
      r_out_data <= w_pack_data;
      r_out_uf   <= w_pack_uf;
      r_out_of   <= w_pack_of;
    end else if (out_ready) begin
      r_s2_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_normalize_pack_float.sv
// Testbench for normalize_pack_float: directed vectors, backpressure,
// randomized traffic against an arithmetic reference model, reset mid-flight.
module tb_normalize_pack_float;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_word;
  logic [5:0]  in_loc;
  logic        in_sign;
  logic [7:0]  in_scale;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_uf;
  logic        out_of;

  int          checks   = 0;
  int          failures = 0;
  int          cur_sc   = 0;
  logic        acc      = 1'b0;
  logic        xfer     = 1'b0;
  logic [33:0] q[$];

  always #5 clk = ~clk;

  normalize_pack_float #(.SCALE_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_word   (in_word),
    .in_loc    (in_loc),
    .in_sign   (in_sign),
    .in_scale  (in_scale),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_uf    (out_uf),
    .out_of    (out_of)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Leading-one detector as seen upstream: 0 for zero, else msb index + 1
  function automatic logic [5:0] loc_of(input logic [31:0] w);
    for (int i = 31; i >= 0; i--) if (w[i]) return 6'(i + 1);
    return 6'd0;
  endfunction

  // Reference: value = w * 2^sc, expressed as {uf, of, binary32}
  function automatic logic [33:0] ref_model(input logic [31:0] w, input logic s, input int sc);
    int     p;
    int     be;
    longint frac;
    longint mant;
`ifdef ROUND_NEAREST_EN
    longint rem;
    longint half;
`endif
    if (w == 32'd0) return {2'b00, s, 31'd0};
    p = 31;
    while (!w[p]) p--;
    frac = longint'(w) - (longint'(1) << p);
    if (p >= 23) begin
      mant = frac >> (p - 23);
`ifdef ROUND_NEAREST_EN
      if (p > 23) begin
        rem  = frac - (mant << (p - 23));
        half = longint'(1) << (p - 24);
        if (rem > half || (rem == half && mant[0])) mant++;
      end
`endif
    end else begin
      mant = frac << (23 - p);
    end
    be = p + 127 + sc;
    if (mant == (longint'(1) << 23)) begin
      mant = 0;
      be++;
    end
    if (be <= 0)   return {2'b10, s, 31'd0};
    if (be >= 255) return {2'b01, s, 8'hFF, 23'd0};
    return {2'b00, s, be[7:0], mant[22:0]};
  endfunction

  task automatic set_beat(input logic [31:0] w, input logic s, input int sc);
    in_word  = w;
    in_loc   = loc_of(w);
    in_sign  = s;
    cur_sc   = sc;
    in_scale = 8'(sc);
  endtask

  task automatic new_beat();
    logic [31:0] w;
    w = ($urandom_range(0, 7) == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
    set_beat(w, 1'($urandom_range(0, 1)), int'($urandom_range(0, 255)) - 128);
  endtask

  // One clock: sample handshakes at the falling edge, score, advance past the rising edge
  task automatic step();
    logic [33:0] exp;
    @(negedge clk);
    xfer = out_valid && out_ready;
    acc  = in_valid && in_ready;
    if (xfer) begin
      checks++;
      assert (q.size() > 0) else begin
        failures++;
        $error("FAIL unexpected_beat observed=0x%0h expected=none", out_data);
      end
      if (q.size() > 0) begin
        exp = q.pop_front();
        check("sb_beat", {30'd0, out_uf, out_of, out_data}, {30'd0, exp});
      end
    end
    if (acc) q.push_back(ref_model(in_word, in_sign, cur_sc));
    @(posedge clk);
    #1;
  endtask

  // Single beat with out_ready high; result must appear exactly two edges after accept
  task automatic directed(input string tag, input logic [31:0] w, input logic [5:0] loc,
                          input logic s, input int sc, input logic [31:0] exp_data,
                          input logic exp_uf, input logic exp_of);
    in_word = w; in_loc = loc; in_sign = s; in_scale = 8'(sc);
    in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    check({tag, "_ready"}, in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check({tag, "_early"}, out_valid, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_data"}, out_data, exp_data);
    check({tag, "_flags"}, {out_uf, out_of}, {exp_uf, exp_of});
    @(posedge clk); #1;
  endtask

  initial begin
    int idx;
    int run;
    int got;
    logic [31:0] bp_w[4];

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_word = '0; in_loc = '0; in_sign = 1'b0; in_scale = '0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_flags", {out_uf, out_of}, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    @(posedge clk); #1;

    // Directed vectors
    directed("one", 32'h1, 6'd1, 1'b0, 0, 32'h3F800000, 1'b0, 1'b0);
    directed("msb_neg", 32'h80000000, 6'd32, 1'b1, 0, 32'hCF000000, 1'b0, 1'b0);
`ifdef ROUND_NEAREST_EN
    directed("round", 32'h01FFFFFF, 6'd25, 1'b0, 0, 32'h4C000000, 1'b0, 1'b0);
`else
    directed("round", 32'h01FFFFFF, 6'd25, 1'b0, 0, 32'h4BFFFFFF, 1'b0, 1'b0);
`endif
    directed("uflow", 32'h1, 6'd1, 1'b0, -128, 32'h00000000, 1'b1, 1'b0);
    directed("oflow", 32'h80000000, 6'd32, 1'b0, 127, 32'h7F800000, 1'b0, 1'b1);
    directed("negzero", 32'h0, 6'd0, 1'b1, 5, 32'h80000000, 1'b0, 1'b0);
    directed("emin", 32'h1, 6'd1, 1'b1, -126, 32'h80800000, 1'b0, 1'b0);
    directed("emax", 32'h1, 6'd1, 1'b0, 127, 32'h7F000000, 1'b0, 1'b0);

    // Backpressure: four beats offered against a stalled consumer
    for (int i = 0; i < 4; i++) bp_w[i] = $urandom | 32'h00000100;
    out_ready = 1'b0; idx = 0; acc = 1'b0;
    for (int c = 0; c < 4; c++) begin
      in_valid = (idx < 4);
      if (idx < 4) set_beat(bp_w[idx], 1'(idx), idx - 2);
      step();
      if (acc) idx++;
    end
    check("bp_accepted", idx, 2);
    check("bp_in_ready_low", in_ready, 0);
    out_ready = 1'b1; run = 0;
    for (int c = 0; c < 4; c++) begin
      in_valid = (idx < 4);
      if (idx < 4) set_beat(bp_w[idx], 1'(idx), idx - 2);
      step();
      if (acc) idx++;
      if (xfer) run++;
    end
    check("bp_no_gaps", run, 4);
    check("bp_all_in", idx, 4);
    in_valid = 1'b0;

    // Randomized traffic with random stalls on both sides
    acc = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if (!in_valid || acc) begin
        in_valid = ($urandom_range(0, 3) != 0);
        if (in_valid) new_beat();
      end
      out_ready = ($urandom_range(0, 2) != 0);
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 10; c++) step();
    check("rand_drained", q.size(), 0);

    // Illegal leading-one position must still produce a beat
    in_word = 32'h12345678; in_loc = 6'd40; in_sign = 1'b0; in_scale = '0;
    in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    check("illegal_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; got = 0;
    for (int c = 0; c < 5 && got == 0; c++) begin
      @(negedge clk);
      if (out_valid) got = 1;
      @(posedge clk); #1;
    end
    check("illegal_emerges", got, 1);
    @(negedge clk);
    check("illegal_single", out_valid, 0);
    @(posedge clk); #1;

    // Reset between edges with a beat held at the output and another in S1
    out_ready = 1'b0;
    in_valid = 1'b1; set_beat(32'h00ABCDEF, 1'b1, 3);
    step();
    set_beat(32'h00000777, 1'b0, -4);
    step();
    in_valid = 1'b0;
    check("mid_rst_pre_valid", out_valid, 1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_data", out_data, 0);
    check("mid_rst_flags", {out_uf, out_of}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    q.delete();
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) step();
    check("post_rst_quiet", out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
